// File: rtl/mac_seq_ctrl.sv
// Sequencer for the 4-lane MAC/adder-tree datapath: streams len x/w groups from a sync-read SRAM and accumulates their dot product.
// Latency: result_valid pulses len+2 clocks after start is accepted (1 clock for len=0); start is ignored while busy.
module mac_seq_ctrl #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int len_bw  = 8,
    parameter int addr_bw = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [len_bw-1:0]    len,
    input  logic [addr_bw-1:0]   base_addr,
    input  logic [psum_bw-1:0]   bias,
    output logic                 busy,
    output logic                 mem_rd,
    output logic [addr_bw-1:0]   mem_addr,
    input  logic [4*bw-1:0]      mem_x_data,
    input  logic [4*bw-1:0]      mem_w_data,
    output logic [4*bw-1:0]      mac_x,
    output logic [4*bw-1:0]      mac_w,
    output logic [psum_bw-1:0]   mac_psum,
    input  logic [psum_bw-1:0]   mac_out,
    output logic [psum_bw-1:0]   result,
    output logic                 result_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [len_bw-1:0]    r_remain;
    logic [addr_bw-1:0]   r_addr;
    logic [psum_bw-1:0]   r_acc;
    logic [psum_bw-1:0]   r_result;
    logic                 r_d_vld;
    logic [psum_bw-1:0]   w_acc_nxt;
    logic                 w_accept;

    assign w_accept = (r_state == S_IDLE) && start;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = (len == '0) ? S_DONE : S_RUN;
            // r_remain counts reads still to issue, including the one issued this cycle
            S_RUN:   if (r_remain == len_bw'(1)) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy         = (r_state != S_IDLE);
    assign mem_rd       = (r_state == S_RUN);
    assign mem_addr     = mem_rd ? r_addr : '0;
    assign mac_x        = r_d_vld ? mem_x_data : '0;
    assign mac_w        = r_d_vld ? mem_w_data : '0;
    assign mac_psum     = r_acc;
    assign w_acc_nxt    = r_d_vld ? mac_out : r_acc;
    assign result       = r_result;
    assign result_valid = (r_state == S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_remain <= '0;
            r_addr   <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_d_vld  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_d_vld <= mem_rd;
            if (w_accept) begin
                r_remain <= len;
                r_addr   <= base_addr;
                r_acc    <= bias;
            end else begin
                r_acc <= w_acc_nxt;
                if (mem_rd) begin
                    r_remain <= r_remain - len_bw'(1);
                    r_addr   <= r_addr + addr_bw'(1);
                end
            end
            // the last group is folded in during DRAIN, so capture the post-add value
            if (w_accept && (len == '0))
                r_result <= bias;
            else if (r_state == S_DRAIN)
                r_result <= w_acc_nxt;
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: directed vector table, busy-ignore and mid-run reset sequences, then random jobs vs a dot-product model.
module tb_mac_seq_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  len;
    logic [7:0]  base_addr;
    logic [15:0] bias;
    logic        busy;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [15:0] mem_x_data;
    logic [15:0] mem_w_data;
    logic [15:0] mac_x;
    logic [15:0] mac_w;
    logic [15:0] mac_psum;
    logic [15:0] mac_out;
    logic [15:0] result;
    logic        result_valid;

    int n_pass = 0;
    int n_tot  = 0;

    logic [15:0] mx [256];
    logic [15:0] mw [256];

    mac_seq_ctrl #(.bw(4), .psum_bw(16), .len_bw(8), .addr_bw(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .len(len),
        .base_addr(base_addr), .bias(bias), .busy(busy), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_x_data(mem_x_data), .mem_w_data(mem_w_data),
        .mac_x(mac_x), .mac_w(mac_w), .mac_psum(mac_psum), .mac_out(mac_out),
        .result(result), .result_valid(result_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // synchronous-read operand SRAM
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_x_data <= mx[mem_addr];
            mem_w_data <= mw[mem_addr];
        end
    end

    // combinational datapath stand-in: sum(x_i*w_i) + psum_in, wrapping at 16 bits
    always_comb begin
        logic [15:0] t;
        t = mac_psum;
        for (int i = 0; i < 4; i++)
            t = t + 16'(mac_x[i*4 +: 4]) * 16'(mac_w[i*4 +: 4]);
        mac_out = t;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [15:0] model_sum(input int l, input int b, input logic [15:0] bs);
        int acc;
        acc = int'(bs);
        for (int g = 0; g < l; g++) begin
            int a;
            a = (b + g) % 256;
            for (int k = 0; k < 4; k++)
                acc += int'(mx[a][k*4 +: 4]) * int'(mw[a][k*4 +: 4]);
        end
        return 16'(acc);
    endfunction

    // Call at a negedge in IDLE; returns at the negedge of the first IDLE cycle after DONE.
    task automatic run_job(input string nm, input int l, input int b, input logic [15:0] bs,
                           input logic [15:0] exp_res, input bit noise);
        int        cyc;
        int        lat;
        bit        got;
        logic [15:0] res;
        logic [7:0]  addrs[$];
        start = 1'b1; len = 8'(l); base_addr = 8'(b); bias = bs;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1; got = 1'b0; lat = 0; res = '0;
        while (!got && cyc <= 400) begin
            if (mem_rd) addrs.push_back(mem_addr);
            if (result_valid) begin
                got = 1'b1; lat = cyc; res = result;
                start = 1'b0;
            end else begin
                if (noise) begin
                    start = 1'($urandom); len = 8'($urandom);
                    base_addr = 8'($urandom); bias = 16'($urandom);
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        chk({nm, "_valid_seen"}, 32'(got), 32'd1);
        chk({nm, "_latency"}, 32'(lat), (l == 0) ? 32'd1 : 32'(l + 2));
        chk({nm, "_result"}, 32'(res), 32'(exp_res));
        chk({nm, "_nreads"}, 32'(addrs.size()), 32'(l));
        for (int i = 0; i < addrs.size() && i < l; i++)
            chk({nm, "_addr"}, 32'(addrs[i]), 32'((b + i) % 256));
        @(negedge clk);
        chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
        chk({nm, "_pulse_1cyc"}, 32'(result_valid), 32'd0);
        chk({nm, "_result_hold"}, 32'(result), 32'(exp_res));
    endtask

    typedef struct {
        string       nm;
        int          l;
        int          b;
        logic [15:0] bs;
        logic [3:0]  xv;
        logic [3:0]  wv;
        logic [15:0] exp_res;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int          pulses;
        int          lat;
        logic [15:0] r1;
        logic [15:0] e1;
        logic [15:0] e2;

        for (int i = 0; i < 256; i++) begin mx[i] = '0; mw[i] = '0; end
        reset_n = 1'b0; start = 1'b0; len = '0; base_addr = '0; bias = '0;
        mem_x_data = '0; mem_w_data = '0;

        vecs[0] = '{"basic",   3, 8'h00, 16'd0,     4'd1, 4'd2, 16'd24};
        vecs[1] = '{"bias_off",1, 8'h10, 16'd100,   4'd3, 4'd3, 16'd136};
        vecs[2] = '{"zero_len",0, 8'h00, 16'd5,     4'd0, 4'd0, 16'd5};
        vecs[3] = '{"acc_wrap",1, 8'h20, 16'hFFF0,  4'd2, 4'd2, 16'h0000};
        vecs[4] = '{"addr_wrap",2,8'hFF, 16'd0,     4'd1, 4'd1, 16'd8};

        @(negedge clk); @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_mac_psum", 32'(mac_psum), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vecs[v].l; i++) begin
                mx[(vecs[v].b + i) % 256] = {4{vecs[v].xv}};
                mw[(vecs[v].b + i) % 256] = {4{vecs[v].wv}};
            end
            run_job(vecs[v].nm, vecs[v].l, vecs[v].b, vecs[v].bs, vecs[v].exp_res, 1'b0);
        end

        // start held high through a len=2 run: only the post-IDLE start may be taken
        for (int i = 0; i < 2; i++) begin mx[8'h40 + i] = 16'($urandom); mw[8'h40 + i] = 16'($urandom); end
        for (int i = 0; i < 4; i++) begin mx[8'h50 + i] = 16'($urandom); mw[8'h50 + i] = 16'($urandom); end
        e1 = model_sum(2, 8'h40, 16'd0);
        e2 = model_sum(4, 8'h50, 16'd7);
        start = 1'b1; len = 8'd2; base_addr = 8'h40; bias = 16'd0;
        @(posedge clk);
        @(negedge clk);
        len = 8'd4; base_addr = 8'h50; bias = 16'd7;
        pulses = 0; r1 = '0;
        for (int c = 1; c <= 4; c++) begin
            if (result_valid) begin pulses++; r1 = result; end
            if (c < 4) @(negedge clk);
        end
        chk("bi_pulses", 32'(pulses), 32'd1);
        chk("bi_result1", 32'(r1), 32'(e1));
        @(negedge clk);
        chk("bi_idle_gap", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("bi_rerun_busy", 32'(busy), 32'd1);
        chk("bi_rerun_addr", 32'(mem_addr), 32'h50);
        lat = 0;
        for (int c = 6; c < 60 && lat == 0; c++) begin
            if (result_valid) lat = c - 5;
            else @(negedge clk);
        end
        chk("bi_latency2", 32'(lat), 32'd6);
        chk("bi_result2", 32'(result), 32'(e2));
        @(negedge clk);

        // asynchronous reset in the middle of a len=5 run
        for (int i = 0; i < 5; i++) begin mx[8'h60 + i] = 16'h3333; mw[8'h60 + i] = 16'h1111; end
        start = 1'b1; len = 8'd5; base_addr = 8'h60; bias = 16'd9;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mr_mac_x_live", 32'(mac_x), 32'h3333);
        #2 reset_n = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_mem_rd", 32'(mem_rd), 32'd0);
        chk("mr_mem_addr", 32'(mem_addr), 32'd0);
        chk("mr_mac_x", 32'(mac_x), 32'd0);
        chk("mr_mac_w", 32'(mac_w), 32'd0);
        chk("mr_mac_psum", 32'(mac_psum), 32'd0);
        chk("mr_result", 32'(result), 32'd0);
        chk("mr_valid", 32'(result_valid), 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        pulses = 0; lat = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (result_valid) pulses++;
            if (busy) lat++;
        end
        chk("mr_no_valid", 32'(pulses), 32'd0);
        chk("mr_no_resume", 32'(lat), 32'd0);
        mx[8'h70] = 16'h4321; mw[8'h70] = 16'h1234;
        run_job("after_rst", 1, 8'h70, 16'd1, model_sum(1, 8'h70, 16'd1), 1'b0);

        // random jobs with random input noise during busy
        for (int j = 0; j < 25; j++) begin
            int          l;
            int          b;
            logic [15:0] bs;
            for (int i = 0; i < 256; i++) begin mx[i] = 16'($urandom); mw[i] = 16'($urandom); end
            l  = (j % 5 == 0) ? 0 : int'($urandom_range(1, 12));
            b  = int'($urandom_range(0, 255));
            bs = 16'($urandom);
            run_job("rand", l, b, bs, model_sum(l, b, bs), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
